// File: rtl/ms_pkg.sv
// Shared definitions for the simple machine: opcodes, control states and
// instruction field positions.
package ms_pkg;

  localparam int OP_W = 2;

  localparam logic [OP_W-1:0] OP_ADD = 2'b00;
  localparam logic [OP_W-1:0] OP_CMP = 2'b01;
  localparam logic [OP_W-1:0] OP_MOV = 2'b10;
  localparam logic [OP_W-1:0] OP_BEQ = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_RD_SRC = 3'd2,
    ST_RD_DST = 3'd3,
    ST_EXEC   = 3'd4
  } state_t;

  // Opcode sits in the top OP_W bits; src directly above dst.
  function automatic int op_lsb(input int data_w);
    return data_w - OP_W;
  endfunction

  function automatic int src_lsb(input int addr_w);
    return addr_w;
  endfunction

endpackage

// File: rtl/ms_alu.sv
// Combinational datapath helper: wrapping add, operand equality and
// zero detect on the sum.
module ms_alu #(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] sum_o,
  output logic              eq_o,
  output logic              zero_o
);

  assign sum_o  = a_i + b_i;
  assign eq_o   = (a_i == b_i);
  assign zero_o = (sum_o == '0);

endmodule

// File: rtl/maquina_sencilla_p.sv
// Multicycle simple-machine core: ADD/CMP/MOV/BEQ over an internal word
// memory, with data operands at or above IO_BASE routed to a req/ack bus.
// DATA_W must be at least 2*ADDR_W+2 so op/src/dst fit in one word.
module maquina_sencilla_p
  import ms_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 7,
  parameter int IO_BASE = 120
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic              io_rd,
  output logic              io_wr,
  output logic [ADDR_W-1:0] io_addr,
  output logic [DATA_W-1:0] io_wdata,
  input  logic [DATA_W-1:0] io_rdata,
  input  logic              io_ack,
  output logic              busy,
  output logic [ADDR_W-1:0] pc,
  output logic              fz,
  output state_t            dbg_state
);

  localparam int                OP_LSB    = op_lsb(DATA_W);
  localparam int                SRC_LSB   = src_lsb(ADDR_W);
  localparam logic [ADDR_W-1:0] IO_BASE_A = ADDR_W'(IO_BASE);
  localparam logic [ADDR_W-1:0] PC_ONE    = ADDR_W'(1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic                fz_q, fz_d;
  logic [DATA_W-1:0]   ir_q, ir_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;

  logic [DATA_W-1:0]   mem_q [2**ADDR_W];
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;

  logic [OP_W-1:0]     ir_op, fetch_op;
  logic [ADDR_W-1:0]   ir_src, ir_dst;
  logic                src_is_io, dst_is_io;
  logic                wr_req, exec_done;
  logic [DATA_W-1:0]   wr_data;
  logic [DATA_W-1:0]   alu_sum;
  logic                alu_eq, alu_zero;

  assign ir_op     = ir_q[OP_LSB +: OP_W];
  assign ir_src    = ir_q[SRC_LSB +: ADDR_W];
  assign ir_dst    = ir_q[ADDR_W-1:0];
  assign fetch_op  = mem_q[pc_q][OP_LSB +: OP_W];
  assign src_is_io = (ir_src >= IO_BASE_A);
  assign dst_is_io = (ir_dst >= IO_BASE_A);

  // Only ADD and MOV write back; an I/O destination holds EXEC until ack.
  assign wr_req    = (ir_op == OP_ADD) || (ir_op == OP_MOV);
  assign wr_data   = (ir_op == OP_MOV) ? a_q : alu_sum;
  assign exec_done = !(wr_req && dst_is_io) || io_ack;

  ms_alu #(.DATA_W(DATA_W)) u_alu (
    .a_i    (a_q),
    .b_i    (b_q),
    .sum_o  (alu_sum),
    .eq_o   (alu_eq),
    .zero_o (alu_zero)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    fz_d      = fz_q;
    ir_d      = ir_q;
    a_d       = a_q;
    b_d       = b_q;
    mem_we    = 1'b0;
    mem_waddr = ir_dst;
    mem_wdata = wr_data;
    io_rd     = 1'b0;
    io_wr     = 1'b0;
    io_addr   = '0;
    io_wdata  = '0;

    case (state_q)
      ST_IDLE: begin
        if (prog_we) begin
          mem_we    = 1'b1;
          mem_waddr = prog_addr;
          mem_wdata = prog_data;
        end
        if (run) state_d = ST_FETCH;
      end

      ST_FETCH: begin
        ir_d    = mem_q[pc_q];
        pc_d    = pc_q + PC_ONE;
        state_d = (fetch_op == OP_BEQ) ? ST_EXEC : ST_RD_SRC;
      end

      ST_RD_SRC: begin
        if (src_is_io) begin
          io_rd   = 1'b1;
          io_addr = ir_src - IO_BASE_A;
          if (io_ack) begin
            a_d     = io_rdata;
            state_d = (ir_op == OP_MOV) ? ST_EXEC : ST_RD_DST;
          end
        end else begin
          a_d     = mem_q[ir_src];
          state_d = (ir_op == OP_MOV) ? ST_EXEC : ST_RD_DST;
        end
      end

      ST_RD_DST: begin
        if (dst_is_io) begin
          io_rd   = 1'b1;
          io_addr = ir_dst - IO_BASE_A;
          if (io_ack) begin
            b_d     = io_rdata;
            state_d = ST_EXEC;
          end
        end else begin
          b_d     = mem_q[ir_dst];
          state_d = ST_EXEC;
        end
      end

      ST_EXEC: begin
        if (wr_req && dst_is_io) begin
          io_wr    = 1'b1;
          io_addr  = ir_dst - IO_BASE_A;
          io_wdata = wr_data;
        end
        if (exec_done) begin
          mem_we = wr_req && !dst_is_io;
          unique case (ir_op)
            OP_ADD:  fz_d = alu_zero;
            OP_CMP:  fz_d = alu_eq;
            OP_MOV:  fz_d = fz_q;
            OP_BEQ:  if (fz_q) pc_d = ir_dst;
          endcase
          state_d = run ? ST_FETCH : ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      fz_q    <= 1'b0;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fz_q    <= fz_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  // Memory contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign busy      = (state_q != ST_IDLE);
  assign pc        = pc_q;
  assign fz        = fz_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_maquina_sencilla_p.sv
// Directed and randomized bench for maquina_sencilla_p with an I/O bus
// responder and an instruction-level reference model.
module tb_maquina_sencilla_p;
  import ms_pkg::*;

  logic        clk, reset, run, prog_we;
  logic [6:0]  prog_addr;
  logic [15:0] prog_data;
  logic        io_rd, io_wr, io_ack, busy, fz;
  logic [6:0]  io_addr, pc;
  logic [15:0] io_wdata, io_rdata;
  state_t      dbg_state;

  maquina_sencilla_p dut (
    .clk(clk), .reset(reset), .run(run), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_data(prog_data),
    .io_rd(io_rd), .io_wr(io_wr), .io_addr(io_addr), .io_wdata(io_wdata),
    .io_rdata(io_rdata), .io_ack(io_ack), .busy(busy), .pc(pc), .fz(fz),
    .dbg_state(dbg_state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int fail_cnt = 0;

  // Transactions are {is_write, io_addr, data}.
  logic [23:0] exp_q[$];
  logic [23:0] obs_q[$];
  logic [15:0] pool [256];
  logic [15:0] m_mem [128];
  int          pool_idx, m_idx;
  int          fixed_wait;
  logic [15:0] fixed_rdata;
  bit          use_pool, spurious_en;
  int          wr_cycles, viol;
  int          age, cur_wait;
  logic [15:0] cur_rdata, hold_wdata;
  logic [6:0]  hold_addr;
  logic        hold_wr;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    chk_cnt++;
    assert (obs === expv) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic load(input logic [6:0] a, input logic [15:0] d);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    tick();
    prog_we = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic run_prog(input int drop_after, output int cyc);
    run = 1'b1;
    tick();
    cyc = 0;
    while (busy && cyc < 200) begin
      if (cyc == drop_after) run = 1'b0;
      tick();
      cyc++;
    end
    run = 1'b0;
  endtask

  function automatic logic [15:0] enc(input logic [1:0] op, input logic [6:0] s, input logic [6:0] d);
    return {op, s, d};
  endfunction

  function automatic logic [6:0] rnd_opnd();
    if ($urandom_range(0, 9) < 3) return 7'(120 + $urandom_range(0, 7));
    return 7'(64 + $urandom_range(0, 55));
  endfunction

  // Bus responder: acks each request after a chosen number of wait cycles.
  initial begin
    io_ack = 1'b0; io_rdata = '0; age = 0; cur_wait = 0;
    forever begin
      @(posedge clk);
      #2;
      if (io_ack) begin io_ack = 1'b0; age = 0; end
      if (io_rd || io_wr) begin
        if (io_rd && io_wr) viol++;
        if (age == 0) begin
          cur_wait   = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, 3));
          hold_addr  = io_addr; hold_wr = io_wr; hold_wdata = io_wdata;
          if (io_rd) begin
            cur_rdata = use_pool ? pool[pool_idx] : fixed_rdata;
            if (use_pool) pool_idx++;
          end
          obs_q.push_back({io_wr, io_addr, io_wr ? io_wdata : cur_rdata});
        end else if (io_addr != hold_addr || io_wr != hold_wr || (io_wr && io_wdata != hold_wdata)) begin
          viol++;
        end
        if (io_wr) wr_cycles++;
        if (age >= cur_wait) begin io_ack = 1'b1; io_rdata = cur_rdata; end
        age++;
      end else begin
        age = 0;
        if (spurious_en) io_ack = 1'($urandom_range(0, 1));
      end
    end
  end

  task automatic m_rd(input logic [6:0] x, output logic [15:0] v);
    if (x >= 7'd120) begin
      v = pool[m_idx];
      m_idx++;
      exp_q.push_back({1'b0, 7'(x - 7'd120), v});
    end else v = m_mem[x];
  endtask

  task automatic m_wr(input logic [6:0] x, input logic [15:0] v);
    if (x >= 7'd120) exp_q.push_back({1'b1, 7'(x - 7'd120), v});
    else m_mem[x] = v;
  endtask

  // Executes the program instruction by instruction until pc reaches stop_pc.
  task automatic run_model(input logic [6:0] stop_pc, output logic m_fz);
    logic [6:0]  mpc;
    logic [15:0] w, a, b, r;
    int          steps;
    mpc = 0; m_fz = 1'b0; steps = 0;
    while (mpc != stop_pc && steps < 1000) begin
      w = m_mem[mpc];
      mpc = mpc + 7'd1;
      steps++;
      case (w[15:14])
        2'b00: begin
          m_rd(w[13:7], a); m_rd(w[6:0], b);
          r = a + b;
          m_wr(w[6:0], r);
          m_fz = (r == 16'd0);
        end
        2'b01: begin
          m_rd(w[13:7], a); m_rd(w[6:0], b);
          m_fz = (a == b);
        end
        2'b10: begin
          m_rd(w[13:7], a);
          m_wr(w[6:0], a);
        end
        default: if (m_fz) mpc = w[6:0];
      endcase
    end
  endtask

  int          cyc, n_end;
  logic        exp_fz;
  logic [15:0] w;

  initial begin
    reset = 1'b0; run = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    fixed_wait = 0; fixed_rdata = '0; use_pool = 1'b0; spurious_en = 1'b0;
    wr_cycles = 0; viol = 0; pool_idx = 0; m_idx = 0;
    tick(); tick();
    reset = 1'b1;
    tick();

    check("rst_pc", pc, 0);
    check("rst_fz", fz, 0);
    check("rst_busy", busy, 0);
    check("rst_io_rd", io_rd, 0);
    check("rst_io_wr", io_wr, 0);
    check("rst_io_addr", io_addr, 0);
    check("rst_io_wdata", io_wdata, 0);
    check("rst_state", dbg_state, ST_IDLE);
    load(7'd10, 16'd5);
    load(7'd11, 16'd7);
    check("prog_m10", dut.mem_q[10], 16'd5);
    check("prog_m11", dut.mem_q[11], 16'd7);

    // ADD 10,11
    load(7'd0, enc(OP_ADD, 7'd10, 7'd11));
    run_prog(0, cyc);
    check("add_cyc", cyc, 4);
    check("add_m11", dut.mem_q[11], 16'd12);
    check("add_fz", fz, 0);
    check("add_pc", pc, 1);

    do_reset();
    load(7'd10, 16'hFFFF);
    load(7'd11, 16'd1);
    run_prog(0, cyc);
    check("addwrap_m11", dut.mem_q[11], 16'd0);
    check("addwrap_fz", fz, 1);

    // CMP then BEQ, taken and not taken
    do_reset();
    load(7'd0, enc(OP_CMP, 7'd10, 7'd10));
    load(7'd1, enc(OP_BEQ, 7'd0, 7'd20));
    run_prog(4, cyc);
    check("beq_t_cyc", cyc, 6);
    check("beq_t_pc", pc, 20);
    check("beq_t_fz", fz, 1);

    do_reset();
    load(7'd0, enc(OP_CMP, 7'd10, 7'd11));
    run_prog(4, cyc);
    check("beq_nt_cyc", cyc, 6);
    check("beq_nt_pc", pc, 2);
    check("beq_nt_fz", fz, 0);

    // MOV from I/O with three wait states
    do_reset();
    load(7'd0, enc(OP_MOV, 7'd120, 7'd12));
    fixed_wait = 3; fixed_rdata = 16'hBEEF;
    obs_q.delete();
    run_prog(0, cyc);
    check("ioread_cyc", cyc, 6);
    check("ioread_m12", dut.mem_q[12], 16'hBEEF);
    check("ioread_n", obs_q.size(), 1);
    check("ioread_txn", obs_q[0], {1'b0, 7'd0, 16'hBEEF});

    // MOV to I/O, zero wait states
    do_reset();
    load(7'd10, 16'd5);
    load(7'd0, enc(OP_MOV, 7'd10, 7'd121));
    fixed_wait = 0; wr_cycles = 0;
    obs_q.delete();
    run_prog(0, cyc);
    check("iowrite_cyc", cyc, 3);
    check("iowrite_wr_cycles", wr_cycles, 1);
    check("iowrite_n", obs_q.size(), 1);
    check("iowrite_txn", obs_q[0], {1'b1, 7'd1, 16'd5});

    // Asynchronous reset while a read is pending
    do_reset();
    load(7'd0, enc(OP_MOV, 7'd120, 7'd12));
    fixed_wait = 100;
    run = 1'b1;
    tick(); tick();
    run = 1'b0;
    check("pend_io_rd", io_rd, 1);
    #2 reset = 1'b0;
    #1;
    check("arst_io_rd", io_rd, 0);
    check("arst_pc", pc, 0);
    check("arst_state", dbg_state, ST_IDLE);
    check("arst_busy", busy, 0);
    tick();
    reset = 1'b1;
    tick();

    // run dropped mid-ADD; prog_we outside IDLE ignored
    load(7'd10, 16'd3);
    load(7'd11, 16'd4);
    load(7'd13, 16'h1111);
    load(7'd0, enc(OP_ADD, 7'd10, 7'd11));
    run = 1'b1;
    tick();
    prog_we = 1'b1; prog_addr = 7'd13; prog_data = 16'h2222;
    tick();
    prog_we = 1'b0; run = 1'b0;
    cyc = 1;
    while (busy && cyc < 200) begin tick(); cyc++; end
    check("halt_cyc", cyc, 4);
    check("halt_m11", dut.mem_q[11], 16'd7);
    check("halt_state", dbg_state, ST_IDLE);
    check("prog_we_busy", dut.mem_q[13], 16'h1111);

    // Random programs against the reference model
    for (int r = 0; r < 2; r++) begin
      do_reset();
      n_end = 24;
      for (int i = 0; i < n_end; i++) begin
        w[15:14] = 2'($urandom_range(0, 3));
        if (w[15:14] == OP_BEQ) w = enc(OP_BEQ, 7'd0, 7'($urandom_range(i + 1, n_end)));
        else w = enc(w[15:14], rnd_opnd(), rnd_opnd());
        m_mem[i] = w;
      end
      m_mem[n_end]     = enc(OP_CMP, 7'd64, 7'd64);
      m_mem[n_end + 1] = enc(OP_BEQ, 7'd0, 7'(n_end + 1));
      for (int a = 64; a < 120; a++) m_mem[a] = (r == 1 && a < 68) ? 16'd0 : 16'($urandom);
      for (int i = 0; i < 256; i++) pool[i] = (i % 7 == 3) ? 16'd0 : 16'($urandom);
      for (int i = 0; i <= n_end + 1; i++) load(7'(i), m_mem[i]);
      for (int a = 64; a < 120; a++) load(7'(a), m_mem[a]);
      exp_q.delete(); obs_q.delete();
      m_idx = 0; pool_idx = 0;
      run_model(7'(n_end + 1), exp_fz);
      use_pool = 1'b1; fixed_wait = -1; spurious_en = 1'b1; viol = 0;
      run = 1'b1;
      tick();
      cyc = 0;
      while (!(dbg_state == ST_FETCH && pc == 7'(n_end + 1)) && cyc < 3000) begin
        tick();
        cyc++;
      end
      check("rnd_reached_end", (cyc < 3000), 1);
      run = 1'b0;
      cyc = 0;
      while (busy && cyc < 100) begin tick(); cyc++; end
      spurious_en = 1'b0;
      check("rnd_idle", busy, 0);
      check("rnd_pc", pc, 7'(n_end + 1));
      check("rnd_fz", fz, exp_fz);
      check("rnd_model_fz", exp_fz, 1);
      for (int a = 64; a < 120; a++) check($sformatf("rnd_mem%0d", a), dut.mem_q[a], m_mem[a]);
      check("rnd_io_n", obs_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
        check($sformatf("rnd_io%0d", i), obs_q[i], exp_q[i]);
      check("rnd_io_protocol", viol, 0);
      use_pool = 1'b0;
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "bench did not complete");
  end

endmodule
